// File: rtl/piso_buf_256b.sv
// -----------------------------------------------------------------------------
// piso_buf_256b
// Parallel-in / serial-out transmit buffer. A host fills a 64 x 32 memory one
// word per write strobe; a start pulse then streams every stored word out,
// word 0 first, MSB first, one bit per cycle accepted by the downstream shift
// consumer. The buffer is emptied when the last bit has been consumed.
//
// Ports
//   clk         in   1   single clock, rising edge
//   reset       in   1   asynchronous, active-low; clears all state
//   pin         in  32   parallel write data
//   pwen        in   1   write strobe (IDLE and not full, else dropped)
//   start       in   1   one-cycle pulse, begins transmission (IDLE, count>0)
//   sen         in   1   downstream accept for the current bit
//   sout        out  1   current serial bit (registered)
//   sout_valid  out  1   sout holds a valid bit (registered)
//   busy        out  1   FSM not in IDLE
//   done        out  1   one-cycle pulse after the last bit is consumed
//   count       out  7   words stored (0..64)
//   full        out  1   count == 64
//   empty       out  1   count == 0
//   ovf         out  1   sticky dropped-write flag, cleared by reset or done
// -----------------------------------------------------------------------------
module piso_buf_256b (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pin,
   input  logic        pwen,
   input  logic        start,
   input  logic        sen,
   output logic        sout,
   output logic        sout_valid,
   output logic        busy,
   output logic        done,
   output logic [6:0]  count,
   output logic        full,
   output logic        empty,
   output logic        ovf
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_mem [0:63];
   logic [31:0] r_dout;
   logic [5:0]  r_wr_ptr;
   logic [5:0]  r_rd_ptr;
   logic [5:0]  r_last_ptr;
   logic [6:0]  r_count;
   logic [31:0] r_shreg;
   logic [4:0]  r_bitcnt;
   logic        r_ovf;
   logic        r_sout_valid;

   logic        w_full;
   logic        w_wr_ok;
   logic        w_start_ok;
   logic        w_bit_acc;
   logic        w_word_end;
   logic        w_last_word;

   assign w_full      = (r_count == 7'd64);
   assign w_wr_ok     = pwen && (r_state == S_IDLE) && !w_full;
   assign w_start_ok  = start && (r_state == S_IDLE) && (r_count != 7'd0);
   assign w_bit_acc   = (r_state == S_SHIFT) && sen;
   assign w_word_end  = w_bit_acc && (r_bitcnt == 5'd31);
   assign w_last_word = (r_rd_ptr == r_last_ptr);

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // ---- FSM: next-state logic ----
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_next = S_FETCH;
         S_FETCH: w_next = S_LOAD;
         S_LOAD:  w_next = S_SHIFT;
         S_SHIFT: if (w_word_end) w_next = w_last_word ? S_DONE : S_FETCH;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   // ---- Storage: synchronous write, registered read ----
   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= pin;
   end

   always_ff @(posedge clk) begin
      if (r_state == S_FETCH) r_dout <= r_mem[r_rd_ptr];
   end

   // ---- Write side: pointer, fill level, overflow flag ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= 6'd0;
         r_count  <= 7'd0;
         r_ovf    <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_wr_ptr <= 6'd0;
         r_count  <= 7'd0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 6'd1;
            r_count  <= r_count + 7'd1;
         end
         if (pwen && !w_wr_ok) r_ovf <= 1'b1;
      end
   end

   // ---- Read side: word pointer ----
   // The last index is captured at start so a write accepted in the same
   // cycle as start does not extend the transmission. For count == 64 the
   // 6-bit subtraction yields 63 as required.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr   <= 6'd0;
         r_last_ptr <= 6'd0;
      end else if (w_start_ok) begin
         r_rd_ptr   <= 6'd0;
         r_last_ptr <= r_count[5:0] - 6'd1;
      end else if (w_word_end && !w_last_word) begin
         r_rd_ptr   <= r_rd_ptr + 6'd1;
      end
   end

   // ---- Shift register and bit counter ----
   // shreg is reset so sout is 0 out of reset; after a full word it has
   // shifted to zero, so sout also reads 0 during FETCH/LOAD gaps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shreg  <= 32'd0;
         r_bitcnt <= 5'd0;
      end else if (r_state == S_LOAD) begin
         r_shreg  <= r_dout;
         r_bitcnt <= 5'd0;
      end else if (w_bit_acc) begin
         r_shreg  <= {r_shreg[30:0], 1'b0};
         r_bitcnt <= r_bitcnt + 5'd1;
      end
   end

   // sout_valid is a flop fed from the next state so the output carries no
   // combinational path from sen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_sout_valid <= 1'b0;
      else        r_sout_valid <= (w_next == S_SHIFT);
   end

   assign sout       = r_shreg[31];
   assign sout_valid = r_sout_valid;
   assign count      = r_count;
   assign full       = w_full;
   assign empty      = (r_count == 7'd0);
   assign ovf        = r_ovf;

endmodule

// File: tb/tb_piso_buf_256b.sv
// -----------------------------------------------------------------------------
// tb_piso_buf_256b
// Directed bench for piso_buf_256b. Inputs change and outputs are sampled on
// the falling clock edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_piso_buf_256b;

   logic        clk;
   logic        reset;
   logic [31:0] pin;
   logic        pwen;
   logic        start;
   logic        sen;
   logic        sout;
   logic        sout_valid;
   logic        busy;
   logic        done;
   logic [6:0]  count;
   logic        full;
   logic        empty;
   logic        ovf;

   int          n_vec;
   int          n_err;
   logic [31:0] exp_w [0:63];

   piso_buf_256b dut (
      .clk        (clk),
      .reset      (reset),
      .pin        (pin),
      .pwen       (pwen),
      .start      (start),
      .sen        (sen),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .done       (done),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   task automatic wr(input logic [31:0] d);
      pin  = d;
      pwen = 1'b1;
      @(negedge clk);
      pwen = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Receive n words, checking each against exp_w. Entered on the falling
   // edge right after start was sampled; returns on the falling edge where
   // done is high, with cyc = falling edges elapsed since entry.
   task automatic rx(input int n, input bit rnd, input string tag, output int cyc);
      logic [31:0] w;
      int          bits;
      int          k;
      bit          seen;
      bit          prev_hold;
      logic        prev_sout;
      w = 32'd0; bits = 0; k = 0; seen = 0; prev_hold = 0; prev_sout = 1'b0;
      while (!seen && k < 5000) begin
         if (prev_hold) chk({tag, "_hold"}, {30'd0, sout_valid, sout}, {30'd0, 1'b1, prev_sout});
         if (done) begin
            seen = 1;
         end else begin
            sen = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sout_valid && sen) begin
               w = {w[30:0], sout};
               bits++;
               if (bits % 32 == 0 && bits / 32 <= 64)
                  chk($sformatf("%s_w%0d", tag, bits / 32 - 1), w, exp_w[bits / 32 - 1]);
            end
            prev_hold = sout_valid && !sen;
            prev_sout = sout;
            @(negedge clk);
            k++;
         end
      end
      sen = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_bits"}, 32'(bits), 32'(32 * n));
      cyc = k;
   endtask

   // Called on the falling edge where done is high.
   task automatic post_done(input string tag);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_count_after"}, 32'(count), 32'd0);
      chk({tag, "_empty_after"}, 32'(empty), 32'd1);
      chk({tag, "_ovf_after"}, 32'(ovf), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sout"}, 32'(sout), 32'd0);
      chk({tag, "_sout_valid"}, 32'(sout_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   initial begin
      int cyc;
      n_vec = 0; n_err = 0;
      reset = 1'b0; pin = 32'd0; pwen = 1'b0; start = 1'b0; sen = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b1;
      @(negedge clk);

      // Single word, MSB first: 1010_0101 ... 0001
      exp_w[0] = 32'hA500_0001;
      wr(32'hA500_0001);
      chk("single_count", 32'(count), 32'd1);
      chk("single_empty", 32'(empty), 32'd0);
      go();
      chk("single_fetch_valid", 32'(sout_valid), 32'd0);
      rx(1, 0, "single", cyc);
      chk("single_latency", 32'(cyc), 32'd34);
      post_done("single");

      // Full buffer plus one overflowing write
      for (int i = 0; i < 64; i++) begin
         exp_w[i] = 32'(i);
         wr(32'(i));
      end
      chk("full_count", 32'(count), 32'd64);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_ovf_clear", 32'(ovf), 32'd0);
      wr(32'hFFFF_FFFF);
      chk("ovf65_count", 32'(count), 32'd64);
      chk("ovf65_flag", 32'(ovf), 32'd1);
      go();
      rx(64, 0, "full", cyc);
      chk("full_latency", 32'(cyc), 32'd2176);
      post_done("full");

      // Write dropped and start ignored while shifting
      exp_w[0] = 32'hDEAD_BEEF;
      wr(32'hDEAD_BEEF);
      sen = 1'b0;
      go();
      @(negedge clk);
      @(negedge clk);
      chk("busy_shift_valid", 32'(sout_valid), 32'd1);
      pin = 32'h1111_1111; pwen = 1'b1; start = 1'b1;
      @(negedge clk);
      pwen = 1'b0; start = 1'b0;
      chk("busy_wr_ovf", 32'(ovf), 32'd1);
      chk("busy_wr_count", 32'(count), 32'd1);
      chk("busy_restart_valid", 32'(sout_valid), 32'd1);
      chk("busy_restart_sout", 32'(sout), 32'd1);
      rx(1, 0, "busy", cyc);
      chk("busy_latency", 32'(cyc), 32'd32);
      post_done("busy");

      // Backpressure with random accept
      exp_w[0] = 32'hFFFF_0000;
      exp_w[1] = 32'h1234_5678;
      exp_w[2] = 32'h8000_0001;
      for (int i = 0; i < 3; i++) wr(exp_w[i]);
      chk("bp_count", 32'(count), 32'd3);
      go();
      rx(3, 1, "bp", cyc);
      post_done("bp");

      // start and pwen together: pre-write count (2) is transmitted
      exp_w[0] = 32'h0F0F_0F0F;
      exp_w[1] = 32'hC3C3_C3C3;
      wr(exp_w[0]);
      wr(exp_w[1]);
      pin = 32'h7777_7777; pwen = 1'b1; start = 1'b1;
      @(negedge clk);
      pwen = 1'b0; start = 1'b0;
      chk("sp_count", 32'(count), 32'd3);
      chk("sp_busy", 32'(busy), 32'd1);
      rx(2, 0, "sp", cyc);
      chk("sp_latency", 32'(cyc), 32'd68);
      post_done("sp");

      // Asynchronous reset in the middle of SHIFT
      wr(32'hAAAA_AAAA);
      wr(32'h5555_5555);
      go();
      sen = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_valid_before", 32'(sout_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      sen = 1'b0;
      reset = 1'b1;
      go();
      chk("rst_start0_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("rst_start0_busy2", 32'(busy), 32'd0);
      chk("rst_start0_valid", 32'(sout_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/piso_buf_256b.md
# piso_buf_256b

Parallel-in/serial-out buffer: the transmit-side counterpart of the 256-byte serial-in/parallel-out capture buffer. A host writes up to 64 32-bit words into a 64×32 memory; on `start` the block streams every stored word out one bit per accepted cycle, word 0 first, MSB first. It feeds a downstream serial consumer (scan/shift interface) and uses the same 64-line memory organisation as the capture side.

## Interface
- No parameters. Depth is fixed at 64 words and width at 32 bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `pin`  in  32  parallel write data.
- `pwen`  in  1  write strobe; stores `pin` at the write pointer.
- `start`  in  1  one-cycle pulse; begins serial transmission of all stored words.
- `sen`  in  1  downstream shift accept; the current bit is consumed on a cycle where `sout_valid` and `sen` are both 1.
- `sout`  out  1  current serial bit.
- `sout_valid`  out  1  `sout` holds a valid bit.
- `busy`  out  1  transmission in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse after the last bit is consumed.
- `count`  out  7  number of words stored (0..64).
- `full`  out  1  `count == 64`.
- `empty`  out  1  `count == 0`.
- `ovf`  out  1  sticky; a write was dropped. Cleared by reset or by `done`.

## Operation
- Storage: 64×32 memory with synchronous write and 1-cycle registered read. 6-bit write pointer `wr_ptr`, 6-bit read pointer `rd_ptr`, 7-bit `count`, 32-bit shift register `shreg`, 5-bit bit counter `bitcnt`.
- Write: in IDLE with `pwen=1` and `!full`, write `pin` to `mem[wr_ptr]`, then increment `wr_ptr` and `count`. If `pwen=1` while full or not in IDLE, the write is dropped and `ovf` is set.
- FSM states: IDLE, FETCH, LOAD, SHIFT, DONE.
  - IDLE: on `start=1` and `count>0`, clear `rd_ptr` and go to FETCH. A `start` with `count==0` is ignored and the FSM stays in IDLE.
  - FETCH: assert memory read at `rd_ptr`, then go to LOAD.
  - LOAD: set `shreg <= mem dout` and `bitcnt <= 0`, then go to SHIFT.
  - SHIFT: `sout = shreg[31]` and `sout_valid = 1`. On `sen=1`, shift `shreg` left by one (zero fill) and increment `bitcnt`. With `sen=0` the block holds; there is no timeout. When the bit with `bitcnt==31` is consumed:
    - if `rd_ptr == count-1`, go to DONE;
    - otherwise increment `rd_ptr` and go to FETCH.
  - DONE: pulse `done=1`, clear `wr_ptr`, `count` and `ovf` (buffer emptied), then go to IDLE.
- `start` is ignored outside IDLE. Simultaneous `start` and `pwen` in IDLE: the write is performed and the transmission covers the pre-write `count`. The `count` update is still applied before DONE clears it.
- `rd_ptr` never wraps within a transmission, since at most 64 words are sent. `wr_ptr` wraps from 63 to 0 only through the DONE clear; `full` blocks further writes at 64.
- Reset mid-operation: FSM returns to IDLE immediately (asynchronous), stored data is discarded (`count=0`), and `sout_valid` drops with no `done` pulse.

## Timing
- Reset values: `sout=0`, `sout_valid=0`, `busy=0`, `done=0`, `count=0`, `full=0`, `empty=1`, `ovf=0`.
- `start` sampled at edge t: FETCH during cycle t+1, LOAD during t+2, first bit valid during t+3.
- Per word: 32 accepted bits, then 2 cycles with `sout_valid=0` (FETCH, LOAD) before the next word.
- N words with `sen` held high: last bit consumed at edge t+3+34N−3; `done` high for the following cycle; `busy` low one cycle later.
- `count`/`full`/`empty` update on the edge after the accepted write. `ovf` sets on the edge after the dropped write.
- `sout` and `sout_valid` are driven from registers only, with no combinational path from `sen`.

## Test plan
- Reset: assert `reset=0` mid-SHIFT → all outputs at their reset values; a following `start` with `count=0` → `busy` stays 0.
- Single word: write 0xA5000001, `start`, `sen=1` → `sout` sequence 1,0,1,0,0,1,0,1,0…0,1 (32 bits); `done` pulses once; `count` returns to 0.
- Full buffer: write words 0..63 with value = index, `start`, `sen=1` → 2048 bits in order; `sout_valid` gaps of 2 cycles between words; `full=1` before start, `empty=1` after `done`.
- Overflow: 65 writes → `count=64`, `ovf=1`; a write during SHIFT → dropped, `ovf=1`; after `done` → `ovf=0`.
- Backpressure: random `sen` during 3-word transfer (0xFFFF0000, 0x12345678, 0x80000001) → recovered stream bit-exact; `sout` stable while `sen=0`.
- Ignored events: `start` while busy → no restart; `start`+`pwen` same cycle with `count=2` → 2 words sent.
